// File: rtl/tff_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tff_toggle_arbiter
// Purpose  : Round-robin arbiter sharing one WIDTH-bit bank of toggle
//            flip-flops among NREQ requesters. The winning requester's mask
//            is latched into a master register, then committed to the bank
//            as q ^ mask, with a registered grant/ack handshake.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-high; clears all state
//            req   - per-requester toggle request (level)
//            mask  - flattened masks, requester i owns mask[i*WIDTH +: WIDTH]
//            gnt   - one-hot grant, registered
//            ack   - one-hot completion, registered, one cycle wide
//            q     - toggle bank state, registered
//            busy  - high whenever a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so a rotation distance of up to NREQ-1 plus NREQ fits.
    localparam int c_DW    = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NREQ - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_COMMIT = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0]   r_master;
    logic [WIDTH-1:0]   r_q;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_ack;

    logic               w_found;
    logic [c_PTR_W-1:0] w_winner;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [WIDTH-1:0]   w_win_mask;
    logic [NREQ-1:0]    w_win_onehot;

    // ------------------------------------------------------------------------
    // Round-robin pick: each requester's priority is its rotational distance
    // from the pointer; the smallest distance among active requests wins.
    // Indices stay loop constants, so every select is a fixed wire slice.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [c_DW-1:0] w_dist;
        logic [c_DW-1:0] w_best;
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_mask = '0;
        w_best     = '1;
        w_dist     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (c_PTR_W'(i) >= r_ptr) begin
                w_dist = {1'b0, c_PTR_W'(i)} - {1'b0, r_ptr};
            end else begin
                w_dist = {1'b0, c_PTR_W'(i)} + c_DW'(NREQ) - {1'b0, r_ptr};
            end
            if (req[i] && (!w_found || (w_dist < w_best))) begin
                w_found    = 1'b1;
                w_best     = w_dist;
                w_winner   = c_PTR_W'(i);
                w_win_mask = mask[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_next_ptr   = (w_winner == c_LAST) ? '0 : (w_winner + 1'b1);
    assign w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_found) w_state_nxt = c_COMMIT;
            c_COMMIT: w_state_nxt = c_DONE;
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered datapath: request capture, bank commit and handshake.
    // req/mask only matter on the IDLE edge; later changes are ignored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_master <= '0;
            r_q      <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win_onehot;
                        r_master <= w_win_mask;
                        r_ptr    <= w_next_ptr;
                    end
                end
                c_COMMIT: begin
                    r_q   <= r_q ^ r_master;
                    // gnt already holds the winner's one-hot code.
                    r_ack <= r_gnt;
                end
                c_DONE: begin
                    r_gnt <= '0;
                    r_ack <= '0;
                end
                default: begin
                    r_gnt <= '0;
                    r_ack <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        busy = (r_state != c_IDLE);
    end

    assign gnt = r_gnt;
    assign ack = r_ack;
    assign q   = r_q;

endmodule
`default_nettype wire

// File: tb/tb_tff_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_toggle_arbiter
// Purpose  : Self-checking bench for tff_toggle_arbiter. A timestamp-based
//            transaction model predicts gnt/ack/q/busy every cycle; directed
//            scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_toggle_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int ack_total = 0;
    bit armed = 0;

    tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .mask (mask),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction model: an accepted request at edge number A shows grant and
    // busy in cycles A and A+1, ack in cycle A+1, and q includes its mask from
    // cycle A+1 on. A new request may be taken at edge A+3 or later.
    // ------------------------------------------------------------------------
    int              cyc;
    int              acc;
    int              m_ptr;
    int              m_w;
    int              idx;
    bit              found;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_mask;
    logic [NREQ-1:0]  e_gnt;
    logic [NREQ-1:0]  e_ack;
    logic [WIDTH-1:0] e_q;
    logic             e_busy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; acc = -10; m_ptr = 0; m_w = 0; m_q = '0; m_mask = '0;
            e_gnt = '0; e_ack = '0; e_q = '0; e_busy = 1'b0;
        end else begin
            if (cyc == acc + 1) m_q = m_q ^ m_mask;
            if (cyc >= acc + 3 && req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        m_w    = idx;
                        m_mask = mask[idx*WIDTH +: WIDTH];
                    end
                end
                acc   = cyc;
                m_ptr = (m_w + 1) % NREQ;
            end
            e_busy = (cyc == acc) || (cyc == acc + 1);
            e_gnt  = e_busy ? NREQ'(1 << m_w) : '0;
            e_ack  = (cyc == acc + 1) ? NREQ'(1 << m_w) : '0;
            e_q    = m_q;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_gnt",  32'(gnt),  32'(e_gnt));
            chk("model_ack",  32'(ack),  32'(e_ack));
            chk("model_q",    32'(q),    32'(e_q));
            chk("model_busy", 32'(busy), 32'(e_busy));
        end
        if (ack != '0) ack_total++;
    end

    // Advance one rising edge; outputs are then stable and inputs may change.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int               ord [5] = '{0, 1, 2, 3, 0};
    logic [WIDTH-1:0] qs  [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    int               a0;

    initial begin
        reset = 1'b1;
        req   = NREQ'($urandom);
        mask  = $urandom;

        // Reset with random inputs.
        tick(); tick();
        armed = 1'b1;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        req   = '0;
        repeat (10) tick();
        chk("idle_q", 32'(q), 32'h00);
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Single transaction, then the same mask again.
        mask = '0;
        mask[7:0] = 8'h0F;
        req = 4'b0001;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_noack", 32'(ack), 32'h0);
        req = '0;
        tick();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_q", 32'(q), 32'h0F);
        tick();
        chk("single_end_busy", 32'(busy), 32'h0);
        chk("single_end_gnt", 32'(gnt), 32'h0);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("repeat_q", 32'(q), 32'h00);
        tick();

        // Rotation under continuous load.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        mask  = {8'h08, 8'h04, 8'h02, 8'h01};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rot_gnt", 32'(gnt), 32'(1 << ord[k]));
            tick();
            chk("rot_ack", 32'(ack), 32'(1 << ord[k]));
            chk("rot_q", 32'(q), 32'(qs[k]));
            if (k == 4) req = '0;
            tick();
        end

        // Pointer wrap: requester 1 wins, then 0101 gives 2 then 0.
        req = 4'b0010;
        tick();
        chk("wrap_gnt1", 32'(gnt), 32'b0010);
        req = '0;
        tick(); tick();
        req = 4'b0101;
        tick();
        chk("wrap_gnt2", 32'(gnt), 32'b0100);
        tick(); tick(); tick();
        chk("wrap_gnt0", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        tick();

        // Late mask change and req drop during COMMIT are ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mask[7:0] = 8'h55;
        req = 4'b0001;
        tick();
        chk("late_busy", 32'(busy), 32'h1);
        a0 = ack_total;
        mask[7:0] = 8'hFF;
        req = '0;
        tick();
        chk("late_ack", 32'(ack), 32'h1);
        chk("late_q", 32'(q), 32'h55);
        tick();
        chk("late_ack_low", 32'(ack), 32'h0);
        tick(); tick();
        chk("late_ack_once", 32'(ack_total - a0), 32'd1);
        chk("late_q_hold", 32'(q), 32'h55);

        // Reset during COMMIT discards the transaction.
        mask[7:0] = 8'h33;
        req = 4'b0001;
        tick();
        chk("rmid_busy", 32'(busy), 32'h1);
        a0 = ack_total;
        req = '0;
        reset = 1'b1;
        #1;
        chk("rmid_q", 32'(q), 32'h00);
        chk("rmid_gnt", 32'(gnt), 32'h0);
        chk("rmid_busy0", 32'(busy), 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("rmid_noack", 32'(ack_total - a0), 32'd0);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("rmid_re_ack", 32'(ack), 32'h1);
        chk("rmid_re_q", 32'(q), 32'h33);
        tick();
        chk("rmid_re_idle", 32'(busy), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tff_toggle_arbiter.md
# tff_toggle_arbiter

Round-robin arbiter that shares one WIDTH-bit bank of toggle flip-flops among NREQ requesters. Each requester presents a toggle mask; the winner's mask is captured into a master register, then committed to the bank as q ^ mask, with a registered grant/ack handshake. It sits between independent control agents and the shared toggle state they each need to flip, so that no two agents update the bank in the same cycle.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the toggle bank
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  per-requester toggle request, level
- mask  in  NREQ*WIDTH  flattened masks; requester i owns mask[i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot completion, registered; high for exactly one cycle
- q  out  WIDTH  toggle bank state, registered
- busy  out  1  high whenever state != IDLE

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, q=0, gnt=0, ack=0, busy=0, master=0, ptr=0.
- FSM states: IDLE, COMMIT, DONE.
- IDLE → COMMIT when req != 0. On that edge:
  - winner = first set req bit searching upward from ptr, wrapping NREQ-1 → 0.
  - gnt <= onehot(winner); master <= mask of winner.
  - ptr <= (winner+1) mod NREQ.
- IDLE with req == 0: stay; q, ptr and master hold.
- COMMIT → DONE unconditionally. On that edge: q <= q ^ master; ack <= onehot(winner).
- DONE → IDLE unconditionally. On that edge: gnt <= 0; ack <= 0.
- Requester contract: drop req on the edge that ends DONE (ack seen high). A req still high in IDLE is treated as a new request.
- Mask and req are sampled only on the IDLE→COMMIT edge. Later changes, including req dropping mid-transaction, do not affect the transaction in flight; it completes and acks.
- mask == 0: full handshake runs; q unchanged.
- Only one transaction is in flight at a time. Requests arriving while busy wait for IDLE.
- q changes only on the COMMIT→DONE edge or on reset.

## Timing
- Edge E0: req sampled in IDLE.
- Cycle after E0 (COMMIT): gnt valid, busy=1.
- Edge E1: q updated.
- Cycle after E1 (DONE): ack=1, new q visible, gnt still high.
- Edge E2: back to IDLE; gnt=0, ack=0.
- Latency: req sampled to q visible is 2 cycles. Throughput: one transaction per 3 cycles under continuous load.
- Reset mid-transaction, in any state, asynchronously forces the reset values. The pending transaction is discarded with no ack, and its requester must re-request.
- Fairness: under continuous requests from all NREQ, each requester is served exactly once per NREQ transactions.

## Test plan
- Reset check: assert reset with random inputs → q=0x00, gnt=0, ack=0, busy=0. Release reset, keep req=0 for 10 cycles → outputs unchanged.
- Single transaction: req=4'b0001, mask0=0x0F → gnt=0001 in the next cycle; ack=0001 and q=0x0F two cycles after sampling; busy low on the third cycle. Repeat with the same mask → q=0x00.
- Rotation: hold req=4'b1111 with masks 0x01/0x02/0x04/0x08 → grant order 0,1,2,3,0. After the first four grants q=0x0F; after requester 0 is served again q=0x0E.
- Pointer wrap: after requester 1 wins, present req=4'b0101 → requester 2 wins, then requester 0.
- Late change ignored: req0 with mask0=0x55; change mask0 to 0xFF and drop req0 during COMMIT → q=0x55, ack0 still pulses once.
- Reset mid-operation: assert reset during COMMIT with mask0=0x33 → q=0x00, ack never pulses. After release, re-request → normal completion with q=0x33.
